// File: rtl/eth_pkg.sv
// Shared constants, error-code bit positions and receive FSM state encoding
// for the Ethernet receive frame sequencer.
package eth_pkg;

   localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
   localparam logic [7:0]  ETH_SFD       = 8'hD5;
   localparam int unsigned ETH_MIN_FRAME = 64;
   localparam logic [47:0] ETH_BCAST     = 48'hFFFF_FFFF_FFFF;

   // frame_errcode bit positions
   localparam int ERR_ADDR  = 0;
   localparam int ERR_RUNT  = 1;
   localparam int ERR_GIANT = 2;

   // One byte of stream latency per slot: the last 4 received bytes are the FCS
   localparam int DLY_DEPTH = 5;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_PREAMBLE = 2'd1,
      ST_DATA     = 2'd2,
      ST_DROP     = 2'd3
   } rx_state_e;

endpackage

// File: rtl/eth_rx_delay_line.sv
// Five-byte shift register holding back the trailing FCS bytes of a frame.
// Slot 0 is the newest byte; the head (oldest) is the next byte to stream out.
module eth_rx_delay_line
   import eth_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        clr_i,
   input  logic        shift_i,
   input  logic [7:0]  din_i,
   output logic [7:0]  head_o,
   output logic [31:0] fcs_o,
   output logic        full_o
);

   logic [7:0] line_q [DLY_DEPTH];
   logic [2:0] occ_q;

   // Shift a new byte in and track occupancy, saturating once all slots are filled
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DLY_DEPTH; i++) line_q[i] <= 8'h00;
         occ_q <= 3'd0;
      end else if (clr_i) begin
         for (int i = 0; i < DLY_DEPTH; i++) line_q[i] <= 8'h00;
         occ_q <= 3'd0;
      end else if (shift_i) begin
         line_q[0] <= din_i;
         for (int i = 1; i < DLY_DEPTH; i++) line_q[i] <= line_q[i-1];
         if (occ_q != 3'(DLY_DEPTH)) occ_q <= occ_q + 3'd1;
      end
   end

   assign head_o = line_q[DLY_DEPTH-1];
   // First FCS byte on the wire is the second-oldest slot; it lands in [7:0]
   assign fcs_o  = {line_q[0], line_q[1], line_q[2], line_q[3]};
   assign full_o = (occ_q == 3'(DLY_DEPTH));

endmodule

// File: rtl/eth_rx_frame_ctrl.sv
// Receive frame sequencer: locks on preamble/SFD, streams frame bytes with the
// FCS held back, filters on destination MAC, flags errors and counts frames.
module eth_rx_frame_ctrl
   import eth_pkg::*;
#(
   parameter logic [47:0] LOCAL_MAC = 48'h00_0A_35_01_FE_C0,
   parameter int unsigned MIN_PRE   = 1,
   parameter int unsigned MAX_LEN   = 1518
) (
   input  logic        mac_rxc,
   input  logic        rst_n,
   input  logic        mac_rxv,
   input  logic [7:0]  mac_rxd,
   input  logic        rx_en,
   input  logic        promisc,
   output logic        out_valid,
   output logic [7:0]  out_data,
   output logic        out_sof,
   output logic        out_eof,
   output logic        out_err,
   output logic        frame_done,
   output logic [15:0] frame_len,
   output logic [31:0] frame_fcs,
   output logic [2:0]  frame_errcode,
   output logic [15:0] ok_cnt,
   output logic [15:0] drop_cnt
);

   rx_state_e   state_q;
   logic [2:0]  pre_cnt_q;
   logic [15:0] byte_cnt_q;
   logic [39:0] dest_q;
   logic        addr_ok_q;
   logic        sof_pend_q;
   logic        out_valid_q, out_sof_q, out_eof_q, out_err_q, frame_done_q;
   logic [7:0]  out_data_q;
   logic [15:0] frame_len_q, ok_cnt_q, drop_cnt_q;
   logic [31:0] frame_fcs_q;
   logic [2:0]  frame_errcode_q;

   logic [7:0]  dl_head;
   logic [31:0] dl_fcs;
   logic        dl_full;
   logic        dl_shift, dl_clr;
   logic [2:0]  errcode_d;
   logic [47:0] dest_d;
   logic        pre_ok;

   // Delay line only runs while inside a frame and starts empty for every frame
   assign dl_shift = (state_q == ST_DATA) && mac_rxv;
   assign dl_clr   = (state_q != ST_DATA);

   eth_rx_delay_line u_dly (
      .clk_i   (mac_rxc),
      .rst_ni  (rst_n),
      .clr_i   (dl_clr),
      .shift_i (dl_shift),
      .din_i   (mac_rxd),
      .head_o  (dl_head),
      .fcs_o   (dl_fcs),
      .full_o  (dl_full)
   );

   assign dest_d = {dest_q, mac_rxd};
   assign pre_ok = ({29'd0, pre_cnt_q} >= MIN_PRE);

   // Error classification of the frame as it stands at its end
   always_comb begin
      errcode_d            = 3'b000;
      errcode_d[ERR_ADDR]  = !addr_ok_q;
      errcode_d[ERR_RUNT]  = (byte_cnt_q < 16'(ETH_MIN_FRAME));
      errcode_d[ERR_GIANT] = ({16'd0, byte_cnt_q} > MAX_LEN);
   end

   // Receive FSM with registered stream, frame-summary and counter outputs
   always_ff @(posedge mac_rxc or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= ST_IDLE;
         pre_cnt_q       <= 3'd0;
         byte_cnt_q      <= 16'd0;
         dest_q          <= 40'd0;
         addr_ok_q       <= 1'b0;
         sof_pend_q      <= 1'b0;
         out_valid_q     <= 1'b0;
         out_data_q      <= 8'h00;
         out_sof_q       <= 1'b0;
         out_eof_q       <= 1'b0;
         out_err_q       <= 1'b0;
         frame_done_q    <= 1'b0;
         frame_len_q     <= 16'd0;
         frame_fcs_q     <= 32'd0;
         frame_errcode_q <= 3'd0;
         ok_cnt_q        <= 16'd0;
         drop_cnt_q      <= 16'd0;
      end else begin
         out_valid_q  <= 1'b0;
         out_sof_q    <= 1'b0;
         out_eof_q    <= 1'b0;
         out_err_q    <= 1'b0;
         frame_done_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (mac_rxv) begin
                  if (!rx_en) begin
                     state_q    <= ST_DROP;
                     drop_cnt_q <= drop_cnt_q + 16'd1;
                  end else if (mac_rxd == ETH_PREAMBLE) begin
                     state_q   <= ST_PREAMBLE;
                     pre_cnt_q <= 3'd1;
                  end else if ((mac_rxd == ETH_SFD) && (MIN_PRE == 0)) begin
                     state_q    <= ST_DATA;
                     byte_cnt_q <= 16'd0;
                     dest_q     <= 40'd0;
                     addr_ok_q  <= 1'b0;
                     sof_pend_q <= 1'b1;
                  end else begin
                     state_q    <= ST_DROP;
                     drop_cnt_q <= drop_cnt_q + 16'd1;
                  end
               end
            end
            ST_PREAMBLE: begin
               if (!mac_rxv) begin
                  state_q <= ST_IDLE;
               end else if (mac_rxd == ETH_PREAMBLE) begin
                  if (pre_cnt_q != 3'd7) pre_cnt_q <= pre_cnt_q + 3'd1;
               end else if ((mac_rxd == ETH_SFD) && pre_ok) begin
                  state_q    <= ST_DATA;
                  byte_cnt_q <= 16'd0;
                  dest_q     <= 40'd0;
                  addr_ok_q  <= 1'b0;
                  sof_pend_q <= 1'b1;
               end else begin
                  state_q    <= ST_DROP;
                  drop_cnt_q <= drop_cnt_q + 16'd1;
               end
            end
            ST_DATA: begin
               if (mac_rxv) begin
                  if (byte_cnt_q != 16'hFFFF) byte_cnt_q <= byte_cnt_q + 16'd1;
                  if (byte_cnt_q < 16'd5) dest_q <= dest_d[39:0];
                  // Sixth destination byte arriving completes the address decision
                  if (byte_cnt_q == 16'd5)
                     addr_ok_q <= promisc || (dest_d == LOCAL_MAC) || (dest_d == ETH_BCAST);
                  if (dl_full) begin
                     out_valid_q <= 1'b1;
                     out_data_q  <= dl_head;
                     out_sof_q   <= sof_pend_q;
                     sof_pend_q  <= 1'b0;
                  end
               end else begin
                  // Frame end: head is the last payload byte, the rest is FCS
                  if (dl_full) begin
                     out_valid_q <= 1'b1;
                     out_data_q  <= dl_head;
                     out_sof_q   <= sof_pend_q;
                     out_eof_q   <= 1'b1;
                     out_err_q   <= |errcode_d;
                  end
                  sof_pend_q      <= 1'b0;
                  frame_done_q    <= 1'b1;
                  frame_len_q     <= byte_cnt_q;
                  frame_fcs_q     <= dl_fcs;
                  frame_errcode_q <= errcode_d;
                  if (|errcode_d) drop_cnt_q <= drop_cnt_q + 16'd1;
                  else            ok_cnt_q   <= ok_cnt_q + 16'd1;
                  state_q <= ST_IDLE;
               end
            end
            ST_DROP: begin
               if (!mac_rxv) state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign out_valid     = out_valid_q;
   assign out_data      = out_data_q;
   assign out_sof       = out_sof_q;
   assign out_eof       = out_eof_q;
   assign out_err       = out_err_q;
   assign frame_done    = frame_done_q;
   assign frame_len     = frame_len_q;
   assign frame_fcs     = frame_fcs_q;
   assign frame_errcode = frame_errcode_q;
   assign ok_cnt        = ok_cnt_q;
   assign drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_eth_rx_frame_ctrl.sv
// Scoreboard bench for eth_rx_frame_ctrl: a frame-level reference model pushes
// expected stream bytes and frame summaries; a monitor pops and compares them.
`timescale 1ns/1ps
module tb_eth_rx_frame_ctrl;

   localparam logic [47:0] LMAC  = 48'h00_0A_35_01_FE_C0;
   localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
   localparam logic [47:0] OTHER = 48'h02_00_00_00_00_01;
   localparam int MINP = 1;
   localparam int MAXL = 1518;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mac_rxv = 1'b0;
   logic [7:0]  mac_rxd = 8'h00;
   logic        rx_en = 1'b1;
   logic        promisc = 1'b0;
   logic        out_valid, out_sof, out_eof, out_err, frame_done;
   logic [7:0]  out_data;
   logic [15:0] frame_len, ok_cnt, drop_cnt;
   logic [31:0] frame_fcs;
   logic [2:0]  frame_errcode;

   eth_rx_frame_ctrl #(.LOCAL_MAC(LMAC), .MIN_PRE(MINP), .MAX_LEN(MAXL)) dut (
      .mac_rxc(clk), .rst_n(rst_n), .mac_rxv(mac_rxv), .mac_rxd(mac_rxd),
      .rx_en(rx_en), .promisc(promisc),
      .out_valid(out_valid), .out_data(out_data), .out_sof(out_sof),
      .out_eof(out_eof), .out_err(out_err), .frame_done(frame_done),
      .frame_len(frame_len), .frame_fcs(frame_fcs), .frame_errcode(frame_errcode),
      .ok_cnt(ok_cnt), .drop_cnt(drop_cnt)
   );

   always #4 clk = ~clk;

   typedef struct packed { logic [7:0] d; logic sof; logic eof; logic err; } srec_t;
   typedef struct packed { logic [15:0] len; logic [31:0] fcs; logic chk; logic [2:0] ec; } drec_t;

   srec_t      sq[$];
   drec_t      dq[$];
   logic [7:0] burst_q[$];
   logic [7:0] frame_q[$];
   int         total = 0;
   int         bad = 0;
   logic [15:0] exp_ok = 16'd0;
   logic [15:0] exp_drop = 16'd0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   // Frame-level model of one contiguous rxv burst starting from idle
   task automatic model_burst(input bit en, input bit prom);
      int n, b0, L;
      logic [47:0] dest;
      logic miss;
      logic [2:0] ec;
      srec_t s;
      drec_t r;
      if (burst_q.size() == 0) return;
      if (!en) begin exp_drop++; return; end
      n = 0;
      while (n < burst_q.size() && burst_q[n] == 8'h55) n++;
      if (n == burst_q.size()) return;
      if (burst_q[n] != 8'hD5 || n < MINP) begin exp_drop++; return; end
      b0 = n + 1;
      L = burst_q.size() - b0;
      dest = '0;
      for (int i = 0; i < 6 && i < L; i++) dest = {dest[39:0], burst_q[b0+i]};
      miss = (L < 6) || !(prom || dest == LMAC || dest == BCAST);
      ec = {L > MAXL, L < 64, miss};
      for (int i = 0; i <= L - 5; i++) begin
         s.d = burst_q[b0+i];
         s.sof = (i == 0);
         s.eof = (i == L - 5);
         s.err = (i == L - 5) ? |ec : 1'b0;
         sq.push_back(s);
      end
      r.len = (L > 65535) ? 16'hFFFF : 16'(L);
      r.chk = (L >= 5);
      r.ec = ec;
      r.fcs = (L >= 5) ? {burst_q[b0+L-1], burst_q[b0+L-2], burst_q[b0+L-3], burst_q[b0+L-4]} : 32'h0;
      dq.push_back(r);
      if (ec == 3'b000) exp_ok++; else exp_drop++;
   endtask

   task automatic build(input int npre, input logic [47:0] dest, input int L);
      burst_q.delete();
      repeat (npre) burst_q.push_back(8'h55);
      burst_q.push_back(8'hD5);
      for (int i = 0; i < L; i++) burst_q.push_back(i < 6 ? dest[47-8*i -: 8] : 8'($urandom));
   endtask

   task automatic settle();
      repeat (12) @(posedge clk);
      #1;
      chk("ok_cnt", 64'(ok_cnt), 64'(exp_ok));
      chk("drop_cnt", 64'(drop_cnt), 64'(exp_drop));
      chk("pending_expect", 64'(sq.size() + dq.size()), 64'd0);
      sq.delete();
      dq.delete();
   endtask

   task automatic send(input bit en, input bit prom, input int en_off);
      promisc = prom;
      rx_en = en;
      model_burst(en, prom);
      foreach (burst_q[i]) begin
         @(posedge clk); #1;
         mac_rxv = 1'b1;
         mac_rxd = burst_q[i];
         if (i == en_off) rx_en = 1'b0;
      end
      @(posedge clk); #1;
      mac_rxv = 1'b0;
      mac_rxd = 8'h00;
      rx_en = 1'b1;
      settle();
   endtask

   task automatic reset_test();
      int cut;
      build(7, LMAC, 64);
      frame_q = burst_q;
      promisc = 1'b0;
      rx_en = 1'b1;
      model_burst(1'b1, 1'b0);
      cut = 8 + 20;
      for (int i = 0; i < cut; i++) begin
         @(posedge clk); #1;
         mac_rxv = 1'b1;
         mac_rxd = frame_q[i];
      end
      @(posedge clk); #1;
      rst_n = 1'b0;
      sq.delete();
      dq.delete();
      exp_ok = 16'd0;
      exp_drop = 16'd0;
      mac_rxd = frame_q[cut];
      #1;
      chk("rst_immediate", {out_valid, frame_done, ok_cnt, drop_cnt}, 64'd0);
      @(posedge clk); #1;
      mac_rxd = frame_q[cut+1];
      @(posedge clk); #1;
      rst_n = 1'b1;
      burst_q.delete();
      for (int k = cut + 2; k < frame_q.size(); k++) burst_q.push_back(frame_q[k]);
      model_burst(1'b1, 1'b0);
      foreach (burst_q[k]) begin
         mac_rxd = burst_q[k];
         @(posedge clk); #1;
      end
      mac_rxv = 1'b0;
      mac_rxd = 8'h00;
      settle();
   endtask

   // Monitor: reset state while rst_n is low, otherwise pop and compare
   initial begin
      srec_t s;
      drec_t r;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            chk("rst_outputs", {out_valid, out_sof, out_eof, out_err, frame_done, out_data}, 64'd0);
            chk("rst_counters", {ok_cnt, drop_cnt}, 64'd0);
            chk("rst_frame", {frame_len, frame_fcs, frame_errcode}, 64'd0);
         end else begin
            if (out_valid) begin
               if (sq.size() == 0) begin
                  total++; bad++;
                  $display("FAIL stream_unexpected actual=%h expected=none", out_data);
               end else begin
                  s = sq.pop_front();
                  chk("stream", {out_data, out_sof, out_eof, out_err}, 64'(s));
               end
            end
            if (frame_done) begin
               if (dq.size() == 0) begin
                  total++; bad++;
                  $display("FAIL done_unexpected actual=len %0d expected=none", frame_len);
               end else begin
                  r = dq.pop_front();
                  chk("frame_summary", {frame_len, (r.chk ? frame_fcs : 32'h0), frame_errcode},
                      {r.len, r.fcs, r.ec});
               end
            end
         end
      end
   end

   initial begin
      int npre, L, sel;
      logic [47:0] dst;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      // clean frame, broadcast, miss, miss under promisc
      build(7, LMAC, 64);  send(1'b1, 1'b0, -1);
      build(7, BCAST, 64); send(1'b1, 1'b0, -1);
      build(7, OTHER, 64); send(1'b1, 1'b0, -1);
      build(7, OTHER, 64); send(1'b1, 1'b1, -1);
      // runt, giant, tiny, empty and exactly-5-byte frames
      build(7, LMAC, 40);   send(1'b1, 1'b0, -1);
      build(7, LMAC, 1600); send(1'b1, 1'b0, -1);
      build(7, LMAC, 3);    send(1'b1, 1'b0, -1);
      build(1, LMAC, 0);    send(1'b1, 1'b0, -1);
      build(2, LMAC, 5);    send(1'b1, 1'b0, -1);
      // bad preamble, then a clean frame
      burst_q = {8'h55, 8'h55, 8'hA5};
      repeat (10) burst_q.push_back(8'($urandom));
      send(1'b1, 1'b0, -1);
      build(2, LMAC, 70); send(1'b1, 1'b0, -1);
      // SFD without preamble, preamble only
      build(0, LMAC, 64); send(1'b1, 1'b0, -1);
      burst_q = {8'h55, 8'h55, 8'h55};
      send(1'b1, 1'b0, -1);
      // rx_en low at frame start, rx_en dropped mid-frame
      build(7, LMAC, 64); send(1'b0, 1'b0, -1);
      build(7, LMAC, 80); send(1'b1, 1'b0, 30);
      // reset in the middle of a frame, then a clean frame
      reset_test();
      build(7, LMAC, 64); send(1'b1, 1'b0, -1);
      // randomized frames
      repeat (30) begin
         npre = $urandom_range(0, 7);
         L = $urandom_range(0, 120);
         sel = $urandom_range(0, 3);
         dst = (sel == 0) ? BCAST : (sel == 1) ? OTHER : LMAC;
         build(npre, dst, L);
         if ($urandom_range(0, 7) == 0) burst_q[npre] = 8'($urandom);
         send($urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)), -1);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
